// File: rtl/mux_n_arb.sv
// N-channel valid/ready stream multiplexer with explicit-select or round-robin grant and one registered output stage.
// Optional packet lock (hold the grant until in_last) is enabled by defining MUX_N_ARB_PKT_LOCK_EN.
module mux_n_arb #(
  parameter int N_CH  = 4,
  parameter int DW    = 8,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [SEL_W-1:0]   out_ch,
  input  logic               out_ready
`ifdef MUX_N_ARB_PKT_LOCK_EN
  ,
  input  logic [N_CH-1:0]    in_last,
  output logic               out_last
`endif
);

  logic [SEL_W-1:0] last_grant;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [N_CH-1:0]  grant_vec;
  logic             load_en;
  logic             xfer;
  logic [DW-1:0]    sel_data;

`ifdef MUX_N_ARB_PKT_LOCK_EN
  typedef enum logic {
    LK_FREE,
    LK_HELD
  } lock_state_e;

  lock_state_e      lock_state;
  logic [SEL_W-1:0] lock_ch;
  logic             sel_last;
`endif

  // The output slot can take a new beat when empty or when it is being drained this cycle.
  assign load_en = ~out_valid | out_ready;

  // NOTE: every variable written in always_comb gets a default at the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : grant_logic
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
`ifdef MUX_N_ARB_PKT_LOCK_EN
    else if (lock_state == LK_HELD) begin
      for (int i = 0; i < N_CH; i++) begin
        if (lock_ch == SEL_W'(i) && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
`endif
    else begin
      // Search starts just after the previous winner and wraps, so the first hit is the fairest.
      for (int off = 1; off <= N_CH; off++) begin
        cand = (int'(last_grant) + off) % N_CH;
        if (!grant_any && in_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(cand);
        end
      end
    end
  end

  assign grant_vec = grant_any ? (N_CH'(1) << grant_idx) : '0;
  assign xfer      = grant_any & load_en & ~rst;
  assign in_ready  = xfer ? grant_vec : '0;

  always_comb begin
    sel_data = '0;
`ifdef MUX_N_ARB_PKT_LOCK_EN
    sel_last = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        sel_data = in_data[i*DW +: DW];
`ifdef MUX_N_ARB_PKT_LOCK_EN
        sel_last = in_last[i];
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N_CH - 1);
`ifdef MUX_N_ARB_PKT_LOCK_EN
      out_last   <= 1'b0;
      lock_state <= LK_FREE;
      lock_ch    <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= grant_idx;
`ifdef MUX_N_ARB_PKT_LOCK_EN
      out_last  <= sel_last;
`endif
      if (mode) begin
        last_grant <= grant_idx;
`ifdef MUX_N_ARB_PKT_LOCK_EN
        if (sel_last) begin
          lock_state <= LK_FREE;
        end else begin
          lock_state <= LK_HELD;
          lock_ch    <= grant_idx;
        end
`endif
      end
    end else if (out_ready) begin
      // Drained with nothing to replace it: data and channel keep their last value.
      out_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot : assert property (@(posedge clk) $onehot0(in_ready));

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_ch)));
`endif

endmodule

// File: tb/tb_mux_n_arb.sv
// Randomised scoreboard bench for mux_n_arb: a rule-level model predicts grants and queues expected beats; a monitor pops them on output handshakes.
// A second 3-channel instance covers the out-of-range select case.
module tb_mux_n_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mode = 1'b0;
  logic [SW-1:0]   sel = '0;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_ch;
  logic            out_ready = 1'b0;

  logic            d3_mode = 1'b0;
  logic [SW-1:0]   d3_sel = '0;
  logic [2:0]      d3_valid = '0;
  logic [3*DW-1:0] d3_data = '0;
  logic [2:0]      d3_ready;
  logic            d3_ov;
  logic [DW-1:0]   d3_od;
  logic [SW-1:0]   d3_och;
  logic            d3_or = 1'b1;

`ifdef MUX_N_ARB_PKT_LOCK_EN
  logic [N-1:0] in_last = '1;
  logic         out_last;
  logic [2:0]   d3_last = '1;
  logic         d3_olast;
`endif

  mux_n_arb #(.N_CH(N), .DW(DW), .SEL_W(SW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef MUX_N_ARB_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  mux_n_arb #(.N_CH(3), .DW(DW), .SEL_W(SW)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (d3_mode),
    .sel       (d3_sel),
    .in_valid  (d3_valid),
    .in_data   (d3_data),
    .in_ready  (d3_ready),
    .out_valid (d3_ov),
    .out_data  (d3_od),
    .out_ch    (d3_och),
    .out_ready (d3_or)
`ifdef MUX_N_ARB_PKT_LOCK_EN
    ,
    .in_last   (d3_last),
    .out_last  (d3_olast)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: producer state, output-slot occupancy, round-robin pointer, expected beats.
  bit            pv[N];
  logic [DW-1:0] pd[N];
  int            m_last;
  bit            m_full;
  beat_t         exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whom the rules say should win this cycle, or -1.
  function automatic int exp_grant();
    if (!mode) return (int'(sel) < N && pv[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      if (pv[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]          = pv[i];
      in_data[i*DW +: DW]  = pd[i];
    end
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && $urandom_range(0, 1) == 1) begin
        pv[i] = 1'b1;
        pd[i] = DW'($urandom);
      end
    end
  endtask

  // One clock: called at posedge+1, returns at the next posedge+1 with the model advanced.
  task automatic cycle();
    int           eg;
    bit           load;
    logic [N-1:0] er;
    beat_t        b;
    drive();
    #1;
    eg   = exp_grant();
    load = !m_full || out_ready;
    er   = (!rst && load && eg >= 0) ? (N'(1) << eg) : '0;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, m_full);
    @(posedge clk);
    #1;
    if (rst) begin
      m_full = 1'b0;
      m_last = N - 1;
      exp_q.delete();
    end else if (er != '0) begin
      b.ch   = eg;
      b.data = pd[eg];
      exp_q.push_back(b);
      m_full = 1'b1;
      if (mode) m_last = eg;
      pv[eg] = 1'b0;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic clear_pv();
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_beat: got ch %0d data %0h, expected no beat", out_ch, out_data);
        end else begin
          b = exp_q.pop_front();
          check("sb_out_data", out_data, b.data);
          check("sb_out_ch", out_ch, b.ch);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] held;
    in_valid = '0;
    in_data  = '0;
    m_last   = N - 1;
    m_full   = 1'b0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    // Reset state, with all inputs requesting during reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1;
      pd[i] = DW'(8'h10 + i);
    end
    mode      = 1'b1;
    out_ready = 1'b1;
    d3_valid  = 3'b111;
    drive();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_d3_ready", d3_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    @(posedge clk);
    #1;
    d3_valid = '0;
    clear_pv();
    rst = 1'b0;

    // Explicit select of channel 2.
    mode  = 1'b0;
    sel   = 2'd2;
    pv[2] = 1'b1;
    pd[2] = 8'hA5;
    cycle();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 8'hA5);
    check("t1_out_ch", out_ch, 2);
    cycle();

    // Round-robin from reset with every channel valid: 0,1,2,3,0,1 back to back.
    rst = 1'b1;
    cycle();
    rst  = 1'b0;
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          pv[i] = 1'b1;
          pd[i] = DW'($urandom);
        end
      end
      cycle();
      check("t2_out_valid", out_valid, 1);
      check("t2_out_ch", out_ch, k % N);
    end

    // Backpressure after the first beat: output frozen on ch1, then ch3 next.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_pv();
    pv[1] = 1'b1;
    pd[1] = 8'h3C;
    pv[3] = 1'b1;
    pd[3] = 8'hC3;
    held  = 8'h3C;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_hold_ch", out_ch, 1);
      check("t3_hold_data", out_data, held);
    end
    out_ready = 1'b1;
    cycle();
    check("t3_next_ch", out_ch, 3);
    cycle();

    // Three-channel instance: sel=3 is out of range and grants nothing.
    clear_pv();
    d3_mode  = 1'b0;
    d3_sel   = 2'd3;
    d3_valid = 3'b111;
    d3_data  = {8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_d3_ready", d3_ready, 0);
      cycle();
      check("t4_d3_out_valid", d3_ov, 0);
    end
    d3_sel = 2'd2;
    #1;
    check("t4_d3_ready_sel2", d3_ready, 3'b100);
    cycle();
    check("t4_d3_out_valid2", d3_ov, 1);
    check("t4_d3_out_ch", d3_och, 2);
    check("t4_d3_out_data", d3_od, 8'h33);
    d3_valid = '0;

    // Reset while holding a round-robin beat from ch2.
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    mode      = 1'b1;
    out_ready = 1'b0;
    pv[2]     = 1'b1;
    pd[2]     = 8'h5A;
    cycle();
    check("t5_pre_ch", out_ch, 2);
    rst   = 1'b1;
    pv[0] = 1'b1;
    pd[0] = 8'h01;
    pv[1] = 1'b1;
    pd[1] = 8'h02;
    pv[3] = 1'b1;
    pd[3] = 8'h04;
    cycle();
    rst = 1'b0;
    check("t5_post_rst_valid", out_valid, 0);
    out_ready = 1'b1;
    cycle();
    check("t5_first_ch", out_ch, 0);

    // Randomised traffic: mode, sel, backpressure and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      refill();
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    // Drain and confirm nothing expected was lost.
    rst = 1'b0;
    clear_pv();
    out_ready = 1'b1;
    repeat (3) cycle();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
